// File: rtl/usr_pkg.sv
// Shared types for the universal shift engine: opcodes, FSM states
// and the per-bit select that steers every usr_cell.
package usr_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SHR  = 2'b01,
        OP_SHL  = 2'b10,
        OP_ROR  = 2'b11
    } usr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } usr_state_e;

    typedef enum logic [1:0] {
        SEL_HOLD       = 2'b00,
        SEL_FROM_LEFT  = 2'b01,
        SEL_FROM_RIGHT = 2'b10,
        SEL_LOAD       = 2'b11
    } usr_sel_e;

    // Right shifts and rotates pull from the upper neighbour,
    // left shifts from the lower one.
    function automatic usr_sel_e op_sel(input usr_op_e op);
        unique case (op)
            OP_LOAD: op_sel = SEL_LOAD;
            OP_SHR:  op_sel = SEL_FROM_LEFT;
            OP_SHL:  op_sel = SEL_FROM_RIGHT;
            OP_ROR:  op_sel = SEL_FROM_LEFT;
            default: op_sel = SEL_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/usr_cell.sv
// One register bit: 4:1 select mux in front of a flip-flop with
// synchronous active-high clear.
module usr_cell
    import usr_pkg::*;
(
    input  logic     clk,
    input  logic     clear,
    input  usr_sel_e sel,
    input  logic     left,
    input  logic     right,
    input  logic     load_bit,
    output logic     q,
    output logic     qbar
);

    logic d;

    always_comb begin
        d = q;
        unique case (sel)
            SEL_HOLD:       d = q;
            SEL_FROM_LEFT:  d = left;
            SEL_FROM_RIGHT: d = right;
            SEL_LOAD:       d = load_bit;
            default:        d = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

    assign qbar = ~q;

endmodule

// File: rtl/usr_shift_engine.sv
// Command-driven universal shift register: a row of usr_cells steered by
// a small FSM that executes one bit-position per clock.
module usr_shift_engine
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             sout_r,
    output logic             sout_l,
    output logic             done
);

    localparam logic [CNT_W-1:0] MAX_AMT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO    = '0;

    usr_state_e       state, state_nxt;
    usr_op_e          op_q, op_nxt, op_in, op_act;
    logic [CNT_W-1:0] remaining, rem_nxt, amt_eff;
    usr_sel_e         sel;
    logic             top_in;
    logic [WIDTH-1:0] upper, lower;

    assign op_in   = usr_op_e'(cmd_op);
    assign amt_eff = (cmd_amt > MAX_AMT) ? MAX_AMT : cmd_amt;

    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= ST_IDLE;
            op_q      <= OP_LOAD;
            remaining <= ZERO;
        end else begin
            state     <= state_nxt;
            op_q      <= op_nxt;
            remaining <= rem_nxt;
        end
    end

    // The first step fires on the accept edge, so IDLE already drives
    // the cell select from the incoming opcode.
    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        rem_nxt   = remaining;
        sel       = SEL_HOLD;
        cmd_ready = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_nxt    = op_in;
                    state_nxt = ST_DONE;
                    rem_nxt   = ZERO;
                    if (op_in == OP_LOAD) begin
                        sel = SEL_LOAD;
                    end else if (amt_eff != ZERO) begin
                        sel = op_sel(op_in);
                        if (amt_eff != ONE) begin
                            state_nxt = ST_RUN;
                            rem_nxt   = amt_eff - ONE;
                        end
                    end
                end
            end
            ST_RUN: begin
                sel     = op_sel(op_q);
                rem_nxt = remaining - ONE;
                if (remaining == ONE) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign op_act = (state == ST_IDLE) ? op_in : op_q;
    assign top_in = (op_act == OP_ROR) ? q[0] : sin_r;
    assign upper  = {top_in, q[WIDTH-1:1]};
    assign lower  = {q[WIDTH-2:0], sin_l};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        usr_cell u_cell (
            .clk      (clk),
            .clear    (clear),
            .sel      (sel),
            .left     (upper[i]),
            .right    (lower[i]),
            .load_bit (cmd_data[i]),
            .q        (q[i]),
            .qbar     (qbar[i])
        );
    end

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_usr_shift_engine.sv
// Directed and random commands against a bit-arithmetic reference of
// the shift register contents and handshake timing.
module tb_usr_shift_engine;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             clear;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_amt;
    logic [WIDTH-1:0] cmd_data;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             sout_r;
    logic             sout_l;
    logic             done;

    int total = 0;
    int bad   = 0;
    int exp_q = 0;

    always #5 clk = ~clk;

    usr_shift_engine #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .clear     (clear),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_amt   (cmd_amt),
        .cmd_data  (cmd_data),
        .sin_r     (sin_r),
        .sin_l     (sin_l),
        .q         (q),
        .qbar      (qbar),
        .sout_r    (sout_r),
        .sout_l    (sout_l),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_q(input string tag);
        int mask;
        mask = (1 << WIDTH) - 1;
        check({tag, "_q"}, 32'(q), 32'(exp_q));
        check({tag, "_qbar"}, 32'(qbar), 32'(~exp_q & mask));
        check({tag, "_sout_r"}, 32'(sout_r), 32'(exp_q % 2));
        check({tag, "_sout_l"}, 32'(sout_l), 32'((exp_q >> (WIDTH - 1)) % 2));
    endtask

    // One single-bit step applied to the expected register value.
    task automatic model_step(input int op, input int sr, input int sl);
        int mask;
        mask = (1 << WIDTH) - 1;
        case (op)
            1: exp_q = (exp_q >> 1) + sr * (1 << (WIDTH - 1));
            2: exp_q = ((exp_q * 2) + sl) & mask;
            3: exp_q = (exp_q >> 1) + (exp_q % 2) * (1 << (WIDTH - 1));
            default: exp_q = exp_q;
        endcase
    endtask

    // Issue one command at a negedge and follow it to the next IDLE cycle.
    // Serial inputs: negative value means random per step.
    task automatic run_cmd(input int op, input int amt, input int data,
                           input int sr_fix, input int sl_fix);
        int steps;
        int k;
        int sr;
        int sl;
        steps = (op == 0) ? 1 : ((amt > WIDTH) ? WIDTH : amt);
        k = (steps == 0) ? 1 : steps;
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_amt   = CNT_W'(amt);
        cmd_data  = WIDTH'(data);
        check("ready_idle", 32'(cmd_ready), 32'd1);
        for (int j = 0; j < k; j++) begin
            sr = (sr_fix < 0) ? int'($urandom_range(0, 1)) : sr_fix;
            sl = (sl_fix < 0) ? int'($urandom_range(0, 1)) : sl_fix;
            sin_r = sr[0];
            sin_l = sl[0];
            @(posedge clk);
            if (op == 0) begin
                exp_q = data & ((1 << WIDTH) - 1);
            end else if (steps > 0) begin
                model_step(op, sr, sl);
            end
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_data  = WIDTH'($urandom);
            check_q("step");
            check("ready_busy", 32'(cmd_ready), 32'd0);
            check("done_step", 32'(done), 32'(j == k - 1));
        end
        @(posedge clk);
        @(negedge clk);
        check("ready_back", 32'(cmd_ready), 32'd1);
        check("done_low", 32'(done), 32'd0);
        check_q("hold");
    endtask

    initial begin
        clear     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_amt   = '0;
        cmd_data  = '0;
        sin_r     = 1'b0;
        sin_l     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_q = 0;
        check_q("reset");
        check("reset_ready", 32'(cmd_ready), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        clear = 1'b0;

        run_cmd(0, 0, 'hA5, 0, 0);
        check("load_a5", 32'(q), 32'hA5);
        run_cmd(1, 3, 0, 1, 0);
        check("shr3", 32'(q), 32'hF4);
        run_cmd(2, 2, 0, 0, 0);
        check("shl2", 32'(q), 32'hD0);
        run_cmd(0, 0, 'h3C, 0, 0);
        run_cmd(3, 4, 0, -1, -1);
        check("ror4", 32'(q), 32'hC3);
        run_cmd(3, 12, 0, -1, -1);
        check("ror12", 32'(q), 32'hC3);

        // Clear on the third step edge of an SHR 6.
        run_cmd(0, 0, 'h3C, 0, 0);
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_amt   = CNT_W'(6);
        sin_r     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        exp_q = 0;
        check_q("abort");
        check("abort_ready", 32'(cmd_ready), 32'd1);
        for (int j = 0; j < 6; j++) begin
            check("abort_nodone", 32'(done), 32'd0);
            @(negedge clk);
        end

        // Clear beats a same-edge accept.
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_data  = 8'hFF;
        clear     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear     = 1'b0;
        cmd_valid = 1'b0;
        check_q("clr_acc");
        check("clr_acc_done", 32'(done), 32'd0);
        @(negedge clk);
        check("clr_acc_done2", 32'(done), 32'd0);

        // cmd_valid held across a busy period: SHL 2 then SHR 0.
        run_cmd(0, 0, 'h96, 0, 0);
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_amt   = CNT_W'(2);
        sin_l     = 1'b1;
        @(posedge clk);
        model_step(2, 0, 1);
        @(negedge clk);
        cmd_op  = 2'd1;
        cmd_amt = '0;
        check("hv_ready0", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        model_step(2, 0, 1);
        @(negedge clk);
        check("hv_done1", 32'(done), 32'd1);
        check("hv_shl", 32'(q), 32'h5B);
        @(negedge clk);
        check("hv_idle", 32'(cmd_ready), 32'd1);
        check("hv_nodone", 32'(done), 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("hv_done2", 32'(done), 32'd1);
        check_q("hv_amt0");

        @(negedge clk);
        for (int n = 0; n < 40; n++) begin
            run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 255)), -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
